// File: rtl/aes_core_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// aes_core_arbiter_pkg
// Shared definitions for the AES core arbiter:
//   state_t            - 2-bit FSM encoding (IDLE, ISSUE, WAIT, DELIVER)
//   ID_TX / ID_RX      - requester identifiers used for owner and `last`
//   TIMEOUT_CYCLES_DEF - default WAIT-cycle budget before a job is aborted
// ---------------------------------------------------------------------------
package aes_core_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_DELIVER = 2'd3
   } state_t;

   localparam logic ID_TX = 1'b0;
   localparam logic ID_RX = 1'b1;

   localparam int TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/aes_core_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin grant select with a registered `last` pointer.
// Ports:
//   clk, g_rst  - clock, synchronous active-high reset
//   i_req_tx    - TX request
//   i_req_rx    - RX request
//   i_take      - the selected requester is being granted this cycle
//   o_any       - at least one request present
//   o_id        - selected requester (ID_TX / ID_RX), valid when o_any=1
// ---------------------------------------------------------------------------
module rr_arb2
   import aes_core_arbiter_pkg::*;
(
   input  logic clk,
   input  logic g_rst,
   input  logic i_req_tx,
   input  logic i_req_rx,
   input  logic i_take,
   output logic o_any,
   output logic o_id
);

   logic r_last;

   always_comb begin
      o_any = i_req_tx | i_req_rx;
      if (i_req_tx && i_req_rx)
         o_id = ~r_last;          // tie: whoever was not served last
      else if (i_req_rx)
         o_id = ID_RX;
      else
         o_id = ID_TX;
   end

   // Reset to RX so TX wins the first tie.
   always_ff @(posedge clk) begin
      if (g_rst)
         r_last <= ID_RX;
      else if (i_take)
         r_last <= o_id;
   end

endmodule

// File: rtl/aes_core_arbiter.sv
// ---------------------------------------------------------------------------
// aes_core_arbiter
// Time-shares one AES-128 core between the CAN XL TX path (tag generation)
// and RX path (tag verification). Grants round-robin, issues a one-cycle
// start with the captured block, waits for completion under a timeout and
// returns the result (or an error) to the granted requester only.
// Ports:
//   clk, g_rst                 - clock, synchronous active-high reset
//   tx_req/tx_data             - TX request (level) and plaintext block
//   tx_gnt/tx_valid/tx_err     - TX ownership, result pulse, timeout pulse
//   tx_result                  - TX ciphertext, held until next TX delivery
//   rx_*                       - same set for RX
//   aes_start/aes_datain       - start pulse and block to the core
//   aes_done/aes_dataout       - core completion level and output block
//   busy                       - high in every state except IDLE
// ---------------------------------------------------------------------------
module aes_core_arbiter
   import aes_core_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int CNT_W          = 8
)(
   input  logic         clk,
   input  logic         g_rst,
   input  logic         tx_req,
   input  logic [127:0] tx_data,
   output logic         tx_gnt,
   output logic         tx_valid,
   output logic         tx_err,
   output logic [127:0] tx_result,
   input  logic         rx_req,
   input  logic [127:0] rx_data,
   output logic         rx_gnt,
   output logic         rx_valid,
   output logic         rx_err,
   output logic [127:0] rx_result,
   output logic         aes_start,
   output logic [127:0] aes_datain,
   input  logic         aes_done,
   input  logic [127:0] aes_dataout,
   output logic         busy
);

   state_t             r_state, w_next;
   logic               r_owner;
   logic               r_ok;       // DELIVER reports valid (1) or err (0)
   logic [CNT_W-1:0]   r_cnt;
   logic [127:0]       r_datain;
   logic [127:0]       r_tx_res;
   logic [127:0]       r_rx_res;
   logic               w_any;
   logic               w_id;
   logic               w_take;
   logic               w_timeout;

   assign w_take    = (r_state == S_IDLE) && w_any;
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   rr_arb2 u_rr (
      .clk      (clk),
      .g_rst    (g_rst),
      .i_req_tx (tx_req),
      .i_req_rx (rx_req),
      .i_take   (w_take),
      .o_any    (w_any),
      .o_id     (w_id)
   );

   always_ff @(posedge clk) begin
      if (g_rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      busy      = 1'b1;
      aes_start = 1'b0;
      tx_gnt    = 1'b0;
      rx_gnt    = 1'b0;
      tx_valid  = 1'b0;
      tx_err    = 1'b0;
      rx_valid  = 1'b0;
      rx_err    = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (w_any)
               w_next = S_ISSUE;
         end
         S_ISSUE: begin
            aes_start = 1'b1;
            w_next    = S_WAIT;
         end
         S_WAIT: begin
            // done and timeout together still leaves via DELIVER; r_ok decides
            if (aes_done || w_timeout)
               w_next = S_DELIVER;
         end
         S_DELIVER: begin
            tx_valid = (r_owner == ID_TX) &&  r_ok;
            tx_err   = (r_owner == ID_TX) && !r_ok;
            rx_valid = (r_owner == ID_RX) &&  r_ok;
            rx_err   = (r_owner == ID_RX) && !r_ok;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (r_state != S_IDLE) begin
         tx_gnt = (r_owner == ID_TX);
         rx_gnt = (r_owner == ID_RX);
      end
   end

   always_ff @(posedge clk) begin
      if (g_rst) begin
         r_owner  <= ID_TX;
         r_ok     <= 1'b0;
         r_cnt    <= '0;
         r_datain <= '0;
         r_tx_res <= '0;
         r_rx_res <= '0;
      end else begin
         if (w_take) begin
            r_owner  <= w_id;
            r_datain <= (w_id == ID_RX) ? rx_data : tx_data;
         end
         if (r_state == S_ISSUE)
            r_cnt <= '0;
         else if (r_state == S_WAIT)
            r_cnt <= r_cnt + 1'b1;
         if (r_state == S_WAIT) begin
            if (aes_done) begin
               r_ok <= 1'b1;
               if (r_owner == ID_RX) r_rx_res <= aes_dataout;
               else                  r_tx_res <= aes_dataout;
            end else if (w_timeout) begin
               r_ok <= 1'b0;
               if (r_owner == ID_RX) r_rx_res <= '0;
               else                  r_tx_res <= '0;
            end
         end
      end
   end

   assign aes_datain = r_datain;
   assign tx_result  = r_tx_res;
   assign rx_result  = r_rx_res;

endmodule

// File: tb/tb_aes_core_arbiter.sv
module tb_aes_core_arbiter;

   localparam int T = 64;

   logic         clk = 1'b0;
   logic         g_rst;
   logic         tx_req, rx_req;
   logic [127:0] tx_data, rx_data;
   logic         tx_gnt, tx_valid, tx_err;
   logic         rx_gnt, rx_valid, rx_err;
   logic [127:0] tx_result, rx_result;
   logic         aes_start, aes_done, busy;
   logic [127:0] aes_datain, aes_dataout;

   always #5 clk = ~clk;

   aes_core_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
      .clk(clk), .g_rst(g_rst),
      .tx_req(tx_req), .tx_data(tx_data), .tx_gnt(tx_gnt), .tx_valid(tx_valid),
      .tx_err(tx_err), .tx_result(tx_result),
      .rx_req(rx_req), .rx_data(rx_data), .rx_gnt(rx_gnt), .rx_valid(rx_valid),
      .rx_err(rx_err), .rx_result(rx_result),
      .aes_start(aes_start), .aes_datain(aes_datain), .aes_done(aes_done),
      .aes_dataout(aes_dataout), .busy(busy)
   );

   int total = 0;
   int bad   = 0;
   logic [127:0] exp_tx_res, exp_rx_res;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit           pre_rst;
      bit           tx;
      bit           rx;
      int           d;        // done asserted d cycles after start; 0 = never
      logic [127:0] data;
      logic [127:0] res;
      bit           exp_id;   // 0 = TX, 1 = RX
      bit           exp_err;
   } row_t;

   row_t rows [7];

   task automatic run_row(input row_t r);
      logic [127:0] own_data, exp_res, other_res;
      int dl;
      bit early;
      if (r.pre_rst) begin
         g_rst = 1'b1; step(); g_rst = 1'b0;
         exp_tx_res = '0; exp_rx_res = '0;
      end
      tx_data  = r.data;
      rx_data  = ~r.data;
      own_data = r.exp_id ? ~r.data : r.data;
      tx_req   = r.tx;
      rx_req   = r.rx;
      aes_done = 1'b0;
      chk("idle_busy", {127'd0, busy}, 128'd0);
      step();
      // ISSUE cycle; requests withdrawn right after grant
      tx_req = 1'b0; rx_req = 1'b0;
      chk("start", {127'd0, aes_start}, 128'd1);
      chk("gnt_owner", {127'd0, r.exp_id ? rx_gnt : tx_gnt}, 128'd1);
      chk("gnt_other", {127'd0, r.exp_id ? tx_gnt : rx_gnt}, 128'd0);
      chk("datain", aes_datain, own_data);
      dl = (r.d >= 1 && r.d <= T) ? r.d + 1 : T + 1;
      exp_res   = r.exp_err ? 128'd0 : r.res;
      other_res = r.exp_id ? exp_tx_res : exp_rx_res;
      early = 1'b0;
      for (int c = 1; c <= dl; c++) begin
         step();
         if (c < dl) begin
            if (tx_valid || tx_err || rx_valid || rx_err || aes_start) early = 1'b1;
            aes_done    = (c == r.d);
            aes_dataout = (c == r.d) ? r.res : 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
         end else begin
            aes_done = 1'b0;
         end
      end
      chk("no_early_pulse", {127'd0, early}, 128'd0);
      chk("own_valid", {127'd0, r.exp_id ? rx_valid : tx_valid}, {127'd0, !r.exp_err});
      chk("own_err",   {127'd0, r.exp_id ? rx_err : tx_err},     {127'd0, r.exp_err});
      chk("other_pulses", {126'd0, r.exp_id ? {tx_valid, tx_err} : {rx_valid, rx_err}}, 128'd0);
      chk("own_result", r.exp_id ? rx_result : tx_result, exp_res);
      chk("other_result", r.exp_id ? tx_result : rx_result, other_res);
      chk("datain_held", aes_datain, own_data);
      if (r.exp_id) exp_rx_res = exp_res; else exp_tx_res = exp_res;
      step();
      chk("back_idle", {124'd0, busy, tx_gnt, rx_gnt, tx_valid | rx_valid}, 128'd0);
   endtask

   // behavioural reference state for the random phase
   bit           m_active, m_owner, m_last;
   int           m_age;       // cycles since the grant decision
   int           m_deliver;   // 0 none, 1 result, 2 timeout
   logic [127:0] m_res [2];
   logic [127:0] m_datain;

   initial begin
      rows[0] = '{0, 1, 0, 50, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 0};
      rows[1] = '{1, 1, 1, 3,  128'h11111111_22222222_33333333_44444444,
                  128'ha5a5a5a5_00000000_ffffffff_12345678, 0, 0};
      rows[2] = '{0, 1, 1, 5,  128'h55555555_66666666_77777777_88888888,
                  128'h0badc0de_0badc0de_0badc0de_0badc0de, 1, 0};
      rows[3] = '{0, 1, 1, 2,  128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc,
                  128'hcafef00d_cafef00d_cafef00d_cafef00d, 0, 0};
      rows[4] = '{0, 0, 1, 0,  128'hdddddddd_eeeeeeee_ffffffff_00000000,
                  128'h12121212_34343434_56565656_78787878, 1, 1};
      rows[5] = '{0, 1, 0, T,  128'h0f0f0f0f_f0f0f0f0_0f0f0f0f_f0f0f0f0,
                  128'h13579bdf_2468ace0_13579bdf_2468ace0, 0, 0};
      rows[6] = '{0, 0, 1, 1,  128'h01020304_05060708_090a0b0c_0d0e0f10,
                  128'hfedcba98_76543210_fedcba98_76543210, 1, 0};

      g_rst = 1'b1; tx_req = 0; rx_req = 0; tx_data = '0; rx_data = '0;
      aes_done = 0; aes_dataout = '0;
      step(); step();
      g_rst = 1'b0;
      exp_tx_res = '0; exp_rx_res = '0;
      chk("rst_ctrl", {120'd0, busy, aes_start, tx_gnt, rx_gnt, tx_valid, tx_err, rx_valid, rx_err}, 128'd0);
      chk("rst_txres", tx_result, 128'd0);
      chk("rst_rxres", rx_result, 128'd0);
      chk("rst_datain", aes_datain, 128'd0);

      for (int i = 0; i < 7; i++) run_row(rows[i]);

      // stray done in IDLE must be ignored
      aes_done = 1'b1; aes_dataout = '1;
      step();
      aes_done = 1'b0;
      chk("stray_done_idle", {124'd0, busy, tx_valid, rx_valid, tx_err | rx_err}, 128'd0);
      chk("stray_done_res", tx_result, exp_tx_res);
      step();
      chk("stray_done_later", {124'd0, busy, tx_valid, rx_valid, tx_err | rx_err}, 128'd0);

      // reset in the middle of WAIT
      rx_data = 128'h77777777_77777777_77777777_77777777;
      rx_req = 1'b1; step(); rx_req = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("midwait_busy", {127'd0, busy}, 128'd1);
      g_rst = 1'b1; step(); g_rst = 1'b0;
      exp_tx_res = '0; exp_rx_res = '0;
      chk("midrst_ctrl", {120'd0, busy, aes_start, tx_gnt, rx_gnt, tx_valid, tx_err, rx_valid, rx_err}, 128'd0);
      chk("midrst_res", tx_result | rx_result, 128'd0);
      chk("midrst_datain", aes_datain, 128'd0);
      aes_done = 1'b1; step(); aes_done = 1'b0;
      chk("midrst_quiet", {124'd0, busy, tx_valid, rx_valid, tx_err | rx_err}, 128'd0);
      // after reset TX must again win a tie
      run_row('{0, 1, 1, 4, 128'h3c3c3c3c_3c3c3c3c_3c3c3c3c_3c3c3c3c,
                128'h4b4b4b4b_4b4b4b4b_4b4b4b4b_4b4b4b4b, 0, 0});

      // randomized phase against the reference model
      for (int c = 0; c < 4000; c++) begin
         logic [7:0] e_ctrl;
         bit pick;
         g_rst       = (c == 0) || ($urandom_range(0, 299) == 0);
         tx_req      = ($urandom_range(0, 2) == 0);
         rx_req      = ($urandom_range(0, 2) == 0);
         tx_data     = {$urandom, $urandom, $urandom, $urandom};
         rx_data     = {$urandom, $urandom, $urandom, $urandom};
         aes_done    = ($urandom_range(0, 39) == 0);
         aes_dataout = {$urandom, $urandom, $urandom, $urandom};
         if (c > 0) begin
            e_ctrl = {m_active, m_active && m_age == 1,
                      m_active && !m_owner, m_active && m_owner,
                      m_deliver == 1 && !m_owner, m_deliver == 2 && !m_owner,
                      m_deliver == 1 && m_owner,  m_deliver == 2 && m_owner};
            chk("rnd_ctrl", {120'd0, busy, aes_start, tx_gnt, rx_gnt, tx_valid, tx_err, rx_valid, rx_err},
                {120'd0, e_ctrl});
            chk("rnd_txres", tx_result, m_res[0]);
            chk("rnd_rxres", rx_result, m_res[1]);
            chk("rnd_datain", aes_datain, m_datain);
         end
         if (g_rst) begin
            m_active = 0; m_owner = 0; m_last = 1; m_age = 0; m_deliver = 0;
            m_res[0] = '0; m_res[1] = '0; m_datain = '0;
         end else if (m_active && m_deliver != 0) begin
            m_active = 0; m_deliver = 0;
         end else if (m_active) begin
            if (m_age >= 2) begin
               if (aes_done) begin
                  m_res[m_owner] = aes_dataout; m_deliver = 1;
               end else if (m_age - 2 == T - 1) begin
                  m_res[m_owner] = '0; m_deliver = 2;
               end
            end
            m_age++;
         end else if (tx_req || rx_req) begin
            pick     = (tx_req && rx_req) ? !m_last : rx_req;
            m_owner  = pick;
            m_last   = pick;
            m_datain = pick ? rx_data : tx_data;
            m_active = 1;
            m_age    = 1;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
